// File: rtl/alu_ctrl_pkg.sv
// Shared types for alu_ctrl: opcode and FSM state enums, instruction header layout, flag record.
package alu_ctrl_pkg;

    typedef enum logic [2:0] {
        OP_NOP = 3'b000,
        OP_LD  = 3'b001,
        OP_ADD = 3'b010,
        OP_SUB = 3'b011,
        OP_NOT = 3'b100,
        OP_AND = 3'b101,
        OP_OR  = 3'b110,
        OP_XOR = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_DONE
    } state_e;

    // Upper eight bits of the instruction word; the immediate sits below at [WIDTH-1:0].
    typedef struct packed {
        op_e        op;
        logic [1:0] rd;
        logic [1:0] rs;
        logic       imm_sel;
    } instr_hdr_t;

    typedef struct packed {
        logic c;
        logic v;
        logic z;
    } flags_t;

    localparam int unsigned HDR_W    = 8;
    localparam int unsigned NUM_REGS = 4;

endpackage

// File: rtl/alu_ctrl_alu.sv
// Combinational ALU for alu_ctrl: result plus {C, V, Z}; C is the borrow for SUB.
module alu
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  op_e              op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             ci_i,
    output logic [WIDTH-1:0] res_o,
    output flags_t           flags_o
);

    localparam int unsigned MSB = WIDTH - 1;

    logic [WIDTH:0]   wide;
    logic [WIDTH-1:0] res;
    logic             c;
    logic             v;

    always_comb begin
        wide = '0;
        res  = '0;
        c    = 1'b0;
        v    = 1'b0;
        case (op_i)
            OP_NOP: res = a_i;
            OP_LD:  res = b_i;
            OP_ADD: begin
                wide = {1'b0, a_i} + {1'b0, b_i} + {{WIDTH{1'b0}}, ci_i};
                res  = wide[WIDTH-1:0];
                c    = wide[WIDTH];
                v    = (a_i[MSB] == b_i[MSB]) && (res[MSB] != a_i[MSB]);
            end
            OP_SUB: begin
                // Bit WIDTH of the extended difference is set exactly when a < b + ci.
                wide = {1'b0, a_i} - {1'b0, b_i} - {{WIDTH{1'b0}}, ci_i};
                res  = wide[WIDTH-1:0];
                c    = wide[WIDTH];
                v    = (a_i[MSB] != b_i[MSB]) && (res[MSB] != a_i[MSB]);
            end
            OP_NOT: res = ~a_i;
            OP_AND: res = a_i & b_i;
            OP_OR:  res = a_i | b_i;
            OP_XOR: res = a_i ^ b_i;
            default: res = a_i;
        endcase
    end

    assign res_o   = res;
    assign flags_o = '{c: c, v: v, z: (res == '0)};

endmodule

// File: rtl/alu_ctrl.sv
// Register-file ALU controller: IDLE/EXEC/DONE handshake around the alu sub-module.
// Optional feature macro: ALU_CTRL_CARRY_CHAIN_EN (ADD/SUB carry-in taken from stored C).
module alu_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH+7:0]   in_instr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [2:0]         out_flags
);

    state_e                   state_q, state_d;
    logic [WIDTH+HDR_W-1:0]   instr_q, instr_d;
    logic [WIDTH-1:0]         regs_q [NUM_REGS];
    logic [WIDTH-1:0]         regs_d [NUM_REGS];
    flags_t                   flags_q, flags_d;
    logic [WIDTH-1:0]         out_data_q, out_data_d;
    flags_t                   out_flags_q, out_flags_d;

    instr_hdr_t               hdr;
    logic [WIDTH-1:0]         imm;
    logic [WIDTH-1:0]         op_a;
    logic [WIDTH-1:0]         op_b;
    logic                     ci;
    logic [WIDTH-1:0]         alu_res;
    flags_t                   alu_flags;

    assign hdr  = instr_hdr_t'(instr_q[WIDTH +: HDR_W]);
    assign imm  = instr_q[WIDTH-1:0];
    // Operands come from registered state, so rd == rs sees the pre-execution value twice.
    assign op_a = regs_q[hdr.rd];
    assign op_b = hdr.imm_sel ? imm : regs_q[hdr.rs];

`ifdef ALU_CTRL_CARRY_CHAIN_EN
    assign ci = flags_q.c;
`else
    assign ci = 1'b0;
`endif

    alu #(.WIDTH(WIDTH)) u_alu (
        .op_i    (hdr.op),
        .a_i     (op_a),
        .b_i     (op_b),
        .ci_i    (ci),
        .res_o   (alu_res),
        .flags_o (alu_flags)
    );

    always_comb begin
        state_d     = state_q;
        instr_d     = instr_q;
        regs_d      = regs_q;
        flags_d     = flags_q;
        out_data_d  = out_data_q;
        out_flags_d = out_flags_q;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    instr_d = in_instr;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (hdr.op != OP_NOP) begin
                    regs_d[hdr.rd] = alu_res;
                    flags_d        = alu_flags;
                    out_data_d     = alu_res;
                    out_flags_d    = alu_flags;
                end else begin
                    out_data_d  = op_a;
                    out_flags_d = flags_q;
                end
                state_d = ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            instr_q     <= '0;
            flags_q     <= '0;
            out_data_q  <= '0;
            out_flags_q <= '0;
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            instr_q     <= instr_d;
            flags_q     <= flags_d;
            out_data_q  <= out_data_d;
            out_flags_q <= out_flags_d;
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    assign out_data  = out_data_q;
    assign out_flags = out_flags_q;

endmodule

// File: tb/tb_alu_ctrl.sv
// Scoreboard bench for alu_ctrl (WIDTH=8); expectations come from a behavioural model in the bench.
module tb_alu_ctrl;

    localparam logic [2:0] NOP = 3'd0, LD = 3'd1, ADD = 3'd2, SUB = 3'd3,
                           NOT = 3'd4, AND = 3'd5, OR = 3'd6, XOR = 3'd7;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [2:0]  out_flags;

    alu_ctrl #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_flags (out_flags)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic [2:0] f;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] m_r [4];
    logic       m_c, m_v, m_z;
    int         n_vec = 0;
    int         n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [15:0] mk(input logic [2:0] op, input logic [1:0] rd,
                                       input logic [1:0] rs, input logic sel, input logic [7:0] imm);
        return {op, rd, rs, sel, imm};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_r[i] = 8'h00;
        m_c = 1'b0; m_v = 1'b0; m_z = 1'b0;
    endtask

    task automatic model_push(input logic [15:0] ins);
        logic [2:0] op;
        logic [7:0] a, b, res;
        int ua, ub, sa, sbv, ci, r, s;
        logic c, v;
        exp_t e;
        op  = ins[15:13];
        a   = m_r[ins[12:11]];
        b   = ins[8] ? ins[7:0] : m_r[ins[10:9]];
        ua  = int'(a);
        ub  = int'(b);
        sa  = int'($signed(a));
        sbv = int'($signed(b));
`ifdef ALU_CTRL_CARRY_CHAIN_EN
        ci = m_c ? 1 : 0;
`else
        ci = 0;
`endif
        c = 1'b0; v = 1'b0; r = 0;
        if (op == NOP) begin
            e.d = a;
            e.f = {m_c, m_v, m_z};
            sb.push_back(e);
            return;
        end
        case (op)
            LD:  r = ub;
            ADD: begin
                r = ua + ub + ci; c = (r > 255);
                s = sa + sbv + ci; v = (s > 127) || (s < -128);
            end
            SUB: begin
                r = ua - ub - ci; c = (r < 0);
                s = sa - sbv - ci; v = (s > 127) || (s < -128);
            end
            NOT: r = ~ua;
            AND: r = ua & ub;
            OR:  r = ua | ub;
            default: r = ua ^ ub;
        endcase
        res = r[7:0];
        m_r[ins[12:11]] = res;
        m_c = c; m_v = v; m_z = (res == 8'h00);
        e.d = res;
        e.f = {m_c, m_v, m_z};
        sb.push_back(e);
    endtask

    task automatic send(input logic [15:0] ins, input bit do_model);
        int n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        if (!in_ready) check_eq("ready_timeout", 32'd0, 32'd1);
        if (do_model) model_push(ins);
        in_valid = 1'b1;
        in_instr = ins;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check_eq("busy_in_exec", in_ready, 1'b0);
    endtask

    task automatic collect();
        int n = 0;
        exp_t e;
        do begin
            @(posedge clk); #1; n++;
        end while (!out_valid && n < 10);
        if (!out_valid) begin
            check_eq("out_valid_timeout", 32'd0, 32'd1);
        end else begin
            check_eq("latency", n + 1, 2);
            if (sb.size() == 0) begin
                check_eq("scoreboard_empty", 32'd0, 32'd1);
            end else begin
                e = sb.pop_front();
                check_eq("data", out_data, e.d);
                check_eq("flags", out_flags, e.f);
            end
        end
    endtask

    task automatic consume();
        @(posedge clk); #1;
        check_eq("consumed", out_valid, 1'b0);
    endtask

    task automatic run(input logic [15:0] ins);
        send(ins, 1'b1);
        collect();
        consume();
    endtask

    task automatic run_k(input logic [15:0] ins, input string tag,
                         input logic [7:0] d, input logic [2:0] f);
        send(ins, 1'b1);
        collect();
        check_eq({tag, "_data"}, out_data, d);
        check_eq({tag, "_flags"}, out_flags, f);
        consume();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [15:0] late;
        logic [31:0] rv;
        rst = 1'b1; in_valid = 1'b0; in_instr = '0; out_ready = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_in_ready", in_ready, 1'b1);
        check_eq("rst_out_valid", out_valid, 1'b0);
        check_eq("rst_out_data", out_data, 8'h00);
        check_eq("rst_out_flags", out_flags, 3'b000);
        rst = 1'b0;
        @(posedge clk); #1;
        check_eq("post_rst_in_ready", in_ready, 1'b1);
        check_eq("post_rst_out_valid", out_valid, 1'b0);

        run_k(mk(NOP, 2'd2, 2'd0, 1'b0, 8'h00), "nop_r2", 8'h00, 3'b000);

        run_k(mk(LD,  2'd1, 2'd0, 1'b1, 8'h7F), "ld_r1",  8'h7F, 3'b000);
        run_k(mk(ADD, 2'd1, 2'd0, 1'b1, 8'h01), "add_ovf", 8'h80, 3'b010);

        run_k(mk(LD,  2'd0, 2'd0, 1'b1, 8'hFF), "ld_r0",  8'hFF, 3'b000);
        run_k(mk(ADD, 2'd0, 2'd0, 1'b1, 8'h01), "add_wrap", 8'h00, 3'b101);
`ifdef ALU_CTRL_CARRY_CHAIN_EN
        run_k(mk(ADD, 2'd2, 2'd0, 1'b1, 8'h00), "add_ci", 8'h01, 3'b000);
`else
        run_k(mk(ADD, 2'd2, 2'd0, 1'b1, 8'h00), "add_ci", 8'h00, 3'b001);
`endif

        run_k(mk(SUB, 2'd3, 2'd0, 1'b1, 8'h01), "sub_borrow", 8'hFF, 3'b100);
        run_k(mk(XOR, 2'd3, 2'd3, 1'b0, 8'h00), "xor_self",   8'h00, 3'b001);

        run(mk(LD,  2'd2, 2'd0, 1'b1, 8'h33));
        run_k(mk(ADD, 2'd2, 2'd2, 1'b0, 8'h00), "add_rdrs", 8'h66, 3'b000);
        run(mk(NOT, 2'd2, 2'd0, 1'b0, 8'h00));
        run(mk(SUB, 2'd1, 2'd1, 1'b0, 8'h00));
        run(mk(OR,  2'd0, 2'd2, 1'b0, 8'h00));
        run(mk(AND, 2'd0, 2'd0, 1'b1, 8'h0F));

        for (int i = 0; i < 24; i++) begin
            rv = $urandom;
            run(rv[15:0]);
        end

        // Backpressure: hold the record in DONE while a new instruction waits on in_valid.
        send(mk(LD, 2'd3, 2'd0, 1'b1, 8'h3C), 1'b1);
        out_ready = 1'b0;
        collect();
        late = mk(LD, 2'd0, 2'd0, 1'b1, 8'hAA);
        in_valid = 1'b1;
        in_instr = late;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check_eq("hold_out_valid", out_valid, 1'b1);
            check_eq("hold_out_data", out_data, 8'h3C);
            check_eq("hold_out_flags", out_flags, 3'b000);
            check_eq("hold_in_ready", in_ready, 1'b0);
        end
        model_push(late);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check_eq("release_idle_ready", in_ready, 1'b1);
        check_eq("release_out_valid", out_valid, 1'b0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check_eq("late_accepted", in_ready, 1'b0);
        collect();
        check_eq("late_data", out_data, 8'hAA);
        consume();

        // Reset while an LD is executing: nothing may be written.
        run(mk(LD, 2'd1, 2'd0, 1'b1, 8'h21));
        send(mk(LD, 2'd1, 2'd0, 1'b1, 8'h55), 1'b0);
        rst = 1'b1;
        #1;
        check_eq("exec_rst_out_valid", out_valid, 1'b0);
        check_eq("exec_rst_in_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check_eq("no_out_after_rst", out_valid, 1'b0);
        end
        run_k(mk(NOP, 2'd1, 2'd0, 1'b0, 8'h00), "nop_r1_after_rst", 8'h00, 3'b000);
        run(mk(NOP, 2'd0, 2'd0, 1'b0, 8'h00));

        if (sb.size() != 0) check_eq("scoreboard_leftover", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
